// File: rtl/bmc_array.sv
// Branch-metric unit for the Viterbi decoder.
// For each received symbol of N soft/hard code bits it computes the metric of
// every one of the 2**N candidate codewords in a 2-stage valid/ready pipeline:
// stage 1 turns each code bit into a pair of distances (to '0' and to '1'),
// stage 2 sums them per codeword, finds the minimum and optionally normalises.
module bmc_array #(
    parameter int N      = 2,
    parameter int SOFT_W = 3,
    parameter int NORM   = 1,
    localparam int NC    = 2**N,
    localparam int SMAX  = 2**SOFT_W - 1,
    localparam int MW    = $clog2(N*SMAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*SOFT_W-1:0]    rx_sym,
    input  logic [N-1:0]           erase,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NC*MW-1:0]       bm,
    output logic [N-1:0]           bm_min_idx
);

    // Pipeline advance conditions: a stage may load when it is empty or when
    // its current content is leaving in this same cycle.
    logic adv1;
    logic adv2;

    logic                s1_valid_reg;
    logic [SOFT_W-1:0]   d0_reg [N];
    logic [SOFT_W-1:0]   d1_reg [N];
    logic [SOFT_W-1:0]   d0_next [N];
    logic [SOFT_W-1:0]   d1_next [N];

    logic                out_valid_reg;
    logic [NC*MW-1:0]    bm_reg;
    logic [N-1:0]        idx_reg;

    logic [MW-1:0]       m_comb [NC];
    logic [MW-1:0]       min_comb;
    logic [N-1:0]        idx_comb;
    logic [NC*MW-1:0]    bm_next;

    assign adv2     = !out_valid_reg || out_ready;
    assign adv1     = !s1_valid_reg || adv2;
    assign in_ready = adv1 && rst_n;

    // Per-bit distances. Soft: distance to '0' is the value itself, distance
    // to '1' is its complement to SMAX. Hard: the MSB is the decision and the
    // distance is 0/1. A punctured bit carries no information either way.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dist
            logic [SOFT_W-1:0] r;
            assign r = rx_sym[gi*SOFT_W +: SOFT_W];
            assign d0_next[gi] = erase[gi] ? '0 :
                                 (mode ? r : SOFT_W'(r[SOFT_W-1]));
            assign d1_next[gi] = erase[gi] ? '0 :
                                 (mode ? (SOFT_W'(SMAX) - r) : SOFT_W'(!r[SOFT_W-1]));
        end
    endgenerate

    // Stage 1 register: capture distances on every input transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            for (int i = 0; i < N; i++) begin
                d0_reg[i] <= '0;
                d1_reg[i] <= '0;
            end
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < N; i++) begin
                    d0_reg[i] <= d0_next[i];
                    d1_reg[i] <= d1_next[i];
                end
            end
        end
    end

    // Codeword metrics: bit i of codeword c selects which distance of bit i counts.
    always_comb begin
        for (int c = 0; c < NC; c++) begin
            m_comb[c] = '0;
            for (int i = 0; i < N; i++) begin
                if (((c >> i) & 1) != 0)
                    m_comb[c] = m_comb[c] + MW'(d1_reg[i]);
                else
                    m_comb[c] = m_comb[c] + MW'(d0_reg[i]);
            end
        end
    end

    // Minimum search; strict compare keeps the lowest index on ties.
    always_comb begin
        min_comb = m_comb[0];
        idx_comb = '0;
        for (int c = 1; c < NC; c++) begin
            if (m_comb[c] < min_comb) begin
                min_comb = m_comb[c];
                idx_comb = N'(c);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NC; gi++) begin : g_norm
            if (NORM != 0) begin : g_sub
                assign bm_next[gi*MW +: MW] = m_comb[gi] - min_comb;
            end else begin : g_raw
                assign bm_next[gi*MW +: MW] = m_comb[gi];
            end
        end
    endgenerate

    // Stage 2 register: outputs hold steady while stalled downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            bm_reg        <= '0;
            idx_reg       <= '0;
        end else if (adv2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                bm_reg  <= bm_next;
                idx_reg <= idx_comb;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign bm         = bm_reg;
    assign bm_min_idx = idx_reg;

endmodule

// File: tb/tb_bmc_array.sv
// Bench for bmc_array (N=2, SOFT_W=3). Two instances share the stimulus: one
// normalising, one raw. A behavioural model computes the expected metrics of
// every accepted symbol into a queue; a per-cycle compare process checks both
// instances against the queue head whenever out_valid is high.
module tb_bmc_array;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  rx_sym;
    logic [1:0]  erase;
    logic        mode;
    logic        out_ready;

    logic        in_ready_n, in_ready_r;
    logic        out_valid_n, out_valid_r;
    logic [15:0] bm_n, bm_r;
    logic [1:0]  idx_n, idx_r;

    int total = 0;
    int bad   = 0;
    int accepted  = 0;
    int delivered = 0;

    typedef struct packed {
        logic [15:0] raw;
        logic [15:0] norm;
        logic [1:0]  idx;
    } exp_t;

    exp_t q[$];

    bmc_array #(.N(2), .SOFT_W(3), .NORM(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .rx_sym(rx_sym), .erase(erase), .mode(mode), .out_valid(out_valid_n),
        .out_ready(out_ready), .bm(bm_n), .bm_min_idx(idx_n)
    );

    bmc_array #(.N(2), .SOFT_W(3), .NORM(0)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .rx_sym(rx_sym), .erase(erase), .mode(mode), .out_valid(out_valid_r),
        .out_ready(out_ready), .bm(bm_r), .bm_min_idx(idx_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Metric of a codeword = total distance between received bits and the
    // codeword's expected bits; erased bits are skipped.
    function automatic exp_t model(input logic [5:0] rx, input logic [1:0] er, input logic md);
        exp_t res;
        int m [4];
        int mn;
        int mi;
        for (int c = 0; c < 4; c++) begin
            m[c] = 0;
            for (int i = 0; i < 2; i++) begin
                int r;
                int e;
                if (er[i]) continue;
                r = int'(rx[3*i +: 3]);
                e = (c >> i) & 1;
                if (md)
                    m[c] += (e == 1) ? (7 - r) : r;
                else
                    m[c] += (((r >= 4) ? 1 : 0) != e) ? 1 : 0;
            end
        end
        mn = m[0];
        mi = 0;
        for (int c = 1; c < 4; c++) begin
            if (m[c] < mn) begin
                mn = m[c];
                mi = c;
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res.raw[c*4 +: 4]  = 4'(m[c]);
            res.norm[c*4 +: 4] = 4'(m[c] - mn);
        end
        res.idx = 2'(mi);
        return res;
    endfunction

    // Per-cycle scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_in_ready_n", {31'b0, in_ready_n}, 0);
            chk("rst_in_ready_r", {31'b0, in_ready_r}, 0);
        end else begin
            chk("valid_pair", {31'b0, out_valid_r}, {31'b0, out_valid_n});
            chk("ready_pair", {31'b0, in_ready_r}, {31'b0, in_ready_n});
            if (out_valid_n) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("sb_bm_norm", {16'b0, bm_n}, {16'b0, q[0].norm});
                    chk("sb_bm_raw",  {16'b0, bm_r}, {16'b0, q[0].raw});
                    chk("sb_idx_n",   {30'b0, idx_n}, {30'b0, q[0].idx});
                    chk("sb_idx_r",   {30'b0, idx_r}, {30'b0, q[0].idx});
                    if (out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                    end
                end
            end
            if (in_valid && in_ready_n) begin
                q.push_back(model(rx_sym, erase, mode));
                accepted++;
            end
        end
    end

    // Present one symbol and hold it until accepted (bounded).
    task automatic send(input logic [2:0] b1, input logic [2:0] b0,
                        input logic [1:0] er, input logic md);
        int n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        rx_sym   = {b1, b0};
        erase    = er;
        mode     = md;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready_n;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    // Send one symbol into an empty pipeline with out_ready high and check
    // latency plus hand-computed metrics; the model is pinned to the same values.
    task automatic lit_test(input string name, input logic [2:0] b1, input logic [2:0] b0,
                            input logic [1:0] er, input logic md,
                            input logic [15:0] raw, input logic [15:0] norm, input logic [1:0] idx);
        exp_t e;
        e = model({b1, b0}, er, md);
        chk({name, "_model_raw"},  {16'b0, e.raw},  {16'b0, raw});
        chk({name, "_model_norm"}, {16'b0, e.norm}, {16'b0, norm});
        chk({name, "_model_idx"},  {30'b0, e.idx},  {30'b0, idx});
        send(b1, b0, er, md);
        @(negedge clk);
        chk({name, "_lat1_valid"}, {31'b0, out_valid_n}, 0);
        @(negedge clk);
        chk({name, "_lat2_valid"}, {31'b0, out_valid_n}, 1);
        chk({name, "_bm_raw"},  {16'b0, bm_r}, {16'b0, raw});
        chk({name, "_bm_norm"}, {16'b0, bm_n}, {16'b0, norm});
        chk({name, "_idx"},     {30'b0, idx_n}, {30'b0, idx});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int acc0;
        int del0;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rx_sym    = '0;
        erase     = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid_n}, 0);
        chk("reset_bm_n", {16'b0, bm_n}, 0);
        chk("reset_bm_r", {16'b0, bm_r}, 0);
        chk("reset_idx", {30'b0, idx_n}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ready", {31'b0, in_ready_n}, 1);
        @(posedge clk);
        #1;

        lit_test("soft_strong", 3'd7, 3'd0, 2'b00, 1'b1, 16'h70E7, 16'h70E7, 2'd2);
        lit_test("hard",        3'd4, 3'd3, 2'b00, 1'b0, 16'h1021, 16'h1021, 2'd2);
        lit_test("soft_43",     3'd4, 3'd3, 2'b00, 1'b1, 16'h7687, 16'h1021, 2'd2);
        lit_test("tie3",        3'd3, 3'd3, 2'b00, 1'b1, 16'h8776, 16'h2110, 2'd0);
        lit_test("tie4",        3'd4, 3'd4, 2'b00, 1'b1, 16'h6778, 16'h0112, 2'd3);
        lit_test("erase10",     3'd5, 3'd0, 2'b10, 1'b1, 16'h7070, 16'h7070, 2'd0);
        lit_test("erase11",     3'd7, 3'd7, 2'b11, 1'b1, 16'h0000, 16'h0000, 2'd0);

        // Back-to-back mixed modes, checked by the scoreboard.
        send(3'd6, 3'd1, 2'b00, 1'b0);
        send(3'd2, 3'd5, 2'b00, 1'b1);
        send(3'd1, 3'd6, 2'b01, 1'b0);
        send(3'd0, 3'd7, 2'b00, 1'b1);
        wait_drain();
        @(posedge clk);
        #1;

        // Backpressure: 5 symbols, out_ready low for 4 cycles.
        acc0 = accepted;
        del0 = delivered;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(3'(k + 1), 3'(6 - k), (k == 3) ? 2'b01 : 2'b00, 1'(k % 2));
            end
        join_none
        repeat (4) @(posedge clk);
        #1;
        chk("bp_accepts", accepted - acc0, 2);
        chk("bp_in_ready", {31'b0, in_ready_n}, 0);
        out_ready = 1'b1;
        n = 0;
        while ((delivered - del0) < 5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("bp_delivered", delivered - del0, 5);
        wait_drain();
        @(posedge clk);
        #1;

        // Reset while two symbols are held.
        out_ready = 1'b0;
        send(3'd7, 3'd0, 2'b00, 1'b1);
        send(3'd3, 3'd3, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("stall_full", {31'b0, in_ready_n}, 0);
        chk("stall_valid", {31'b0, out_valid_n}, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'b0, out_valid_n}, 0);
        chk("midrst_bm_n", {16'b0, bm_n}, 0);
        chk("midrst_bm_r", {16'b0, bm_r}, 0);
        chk("midrst_idx", {30'b0, idx_n}, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        lit_test("post_rst", 3'd4, 3'd4, 2'b00, 1'b1, 16'h6778, 16'h0112, 2'd3);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
